// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 slave in front of a word-organised SRAM, serving one burst at a time.
// Reads have priority over writes; per-beat DECERR/SLVERR suppress the SRAM access.
module axi_sram_slave #(
    parameter int                    AXI_ADDR_WIDTH  = 32,
    parameter int                    AXI_DATA_WIDTH  = 32,
    parameter int                    AXI_ID_WIDTH    = 4,
    parameter int                    AXI_STRB_WIDTH  = AXI_DATA_WIDTH / 8,
    parameter int                    MEM_DEPTH_WORDS = 4096,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AXI_ID_WIDTH-1:0]   awid,
    input  logic [AXI_ADDR_WIDTH-1:0] awaddr,
    input  logic [7:0]                awlen,
    input  logic [1:0]                awburst,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [AXI_DATA_WIDTH-1:0] wdata,
    input  logic [AXI_STRB_WIDTH-1:0] wstrb,
    input  logic                      wlast,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [AXI_ID_WIDTH-1:0]   bid,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    input  logic [AXI_ID_WIDTH-1:0]   arid,
    input  logic [AXI_ADDR_WIDTH-1:0] araddr,
    input  logic [7:0]                arlen,
    input  logic [1:0]                arburst,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [AXI_ID_WIDTH-1:0]   rid,
    output logic [AXI_DATA_WIDTH-1:0] rdata,
    output logic [1:0]                rresp,
    output logic                      rlast,
    output logic                      rvalid,
    input  logic                      rready
);
    localparam int IW = $clog2(MEM_DEPTH_WORDS);
    localparam logic [AXI_ADDR_WIDTH:0] MEM_BYTES = (AXI_ADDR_WIDTH+1)'(4 * MEM_DEPTH_WORDS);
    localparam logic [1:0] FIXED = 2'b00, WRAP = 2'b10, RSVD = 2'b11;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;
    typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;
    state_t state, state_d;
    logic [AXI_ID_WIDTH-1:0]   id_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_inc, addr_next, wrap_mask;
    logic [AXI_ADDR_WIDTH:0]   off;
    logic [7:0]                len_q, cnt_q;
    logic [1:0]                burst_q, err_q, beat_resp, w_resp;
    logic [IW-1:0]             idx;
    logic                      in_range, wrap_len_ok, cnt_last, w_end, w_fire, r_fire;
    logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH_WORDS];
    assign off         = {1'b0, addr_q} - {1'b0, BASE_ADDR};
    assign in_range    = off < MEM_BYTES;
    assign idx         = off[IW+1:2];
    assign wrap_len_ok = len_q == 8'd1 || len_q == 8'd3 || len_q == 8'd7 || len_q == 8'd15;
    assign beat_resp   = !in_range ? DECERR :
                         (burst_q == RSVD || (burst_q == WRAP && !wrap_len_ok)) ? SLVERR : OKAY;
    // Wrap window is (len+1)*4 bytes, so its offset mask is simply {len, 2'b11}.
    assign wrap_mask   = {{(AXI_ADDR_WIDTH-10){1'b0}}, len_q, 2'b11};
    assign addr_inc    = addr_q + AXI_ADDR_WIDTH'(4);
    assign addr_next   = burst_q == FIXED ? addr_q :
                         burst_q == WRAP  ? (addr_q & ~wrap_mask) | (addr_inc & wrap_mask) : addr_inc;
    assign cnt_last    = cnt_q == len_q;
    assign w_end       = wlast || cnt_last;
    assign w_resp      = beat_resp | ((wlast != cnt_last) ? SLVERR : OKAY);
    assign w_fire      = wready && wvalid;
    assign r_fire      = rvalid && rready;
    always_comb begin
        state_d = state;
        {awready, arready, wready, bvalid, rvalid} = '0;
        case (state)
            IDLE: begin
                state_d = arvalid ? RDATA : (awvalid ? WDATA : IDLE);
                arready = 1'b1;
                awready = !arvalid;
            end
            WDATA: begin
                state_d = (wvalid && w_end) ? WRESP : WDATA;
                wready  = 1'b1;
            end
            WRESP: begin
                state_d = bready ? IDLE : WRESP;
                bvalid  = 1'b1;
            end
            RDATA: begin
                state_d = (rready && cnt_last) ? IDLE : RDATA;
                rvalid  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (rst) {awready, arready, wready, bvalid, rvalid} = '0;
    end
    assign bid   = bvalid ? id_q : '0;
    assign bresp = bvalid ? err_q : OKAY;
    assign rid   = rvalid ? id_q : '0;
    assign rresp = rvalid ? beat_resp : OKAY;
    assign rlast = rvalid && cnt_last;
    assign rdata = (rvalid && beat_resp == OKAY) ? mem[idx] : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            burst_q <= '0;
            cnt_q   <= '0;
            err_q   <= OKAY;
        end else begin
            state <= state_d;
            if (state == IDLE && (arvalid || awvalid)) begin
                id_q    <= arvalid ? arid : awid;
                addr_q  <= arvalid ? araddr : awaddr;
                len_q   <= arvalid ? arlen : awlen;
                burst_q <= arvalid ? arburst : awburst;
                cnt_q   <= '0;
                err_q   <= OKAY;
            end
            if (w_fire || r_fire) begin
                cnt_q  <= cnt_q + 8'd1;
                addr_q <= addr_next;
            end
            if (w_fire) err_q <= err_q | w_resp;
        end
    end
    always_ff @(posedge clk) begin
        for (int b = 0; b < AXI_STRB_WIDTH; b++)
            if (w_fire && beat_resp == OKAY && wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: randomized and directed AXI bursts checked against an array model of the SRAM.
module tb_axi_sram_slave;
    localparam int DEPTH = 4096;
    localparam logic [31:0] BASE = 32'h0;
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10, RSVD = 2'b11;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

    logic clk = 1'b0, rst = 1'b1;
    logic [3:0] awid = '0, arid = '0, bid, rid;
    logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
    logic [7:0] awlen = '0, arlen = '0;
    logic [1:0] awburst = '0, arburst = '0, bresp, rresp;
    logic [3:0] wstrb = '0;
    logic awvalid = 0, wlast = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic awready, wready, bvalid, arready, rlast, rvalid;

    int checks = 0, errors = 0;
    logic [31:0] model [DEPTH];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];

    axi_sram_slave dut (
        .clk(clk), .rst(rst),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit wrap_ok(int len);
        return len == 1 || len == 3 || len == 7 || len == 15;
    endfunction

    function automatic logic [31:0] beat_addr(logic [31:0] a, int len, logic [1:0] burst, int i);
        logic [31:0] size, base;
        if (burst == FIXED) return a;
        if (burst == WRAP && wrap_ok(len)) begin
            size = 32'((len + 1) * 4);
            base = a - (a % size);
            return base + ((a - base + 32'(4 * i)) % size);
        end
        return a + 32'(4 * i);
    endfunction

    function automatic logic [1:0] resp_of(logic [31:0] a, int len, logic [1:0] burst);
        if (a - BASE >= 32'(4 * DEPTH)) return DECERR;
        if (burst == RSVD || (burst == WRAP && !wrap_ok(len))) return SLVERR;
        return OKAY;
    endfunction

    function automatic int idx_of(logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [1:0] exp_bresp(logic [31:0] a, int len, logic [1:0] burst, int wlast_at);
        logic [1:0] r = OKAY, x;
        int n = (wlast_at < len ? wlast_at : len) + 1;
        for (int i = 0; i < n; i++) begin
            x = resp_of(beat_addr(a, len, burst, i), len, burst);
            if (x > r) r = x;
        end
        if (wlast_at != len && SLVERR > r) r = SLVERR;
        return r;
    endfunction

    task automatic do_write(input logic [3:0] id, input logic [31:0] a, input int len, input logic [1:0] burst,
                            input int wlast_at, output logic [1:0] resp, output logic [3:0] idv);
        int n = (wlast_at < len ? wlast_at : len) + 1;
        int t;
        logic [31:0] ea;
        @(negedge clk);
        awid = id; awaddr = a; awlen = 8'(len); awburst = burst; awvalid = 1; #1;
        t = 0;
        while (!awready && t < 50) begin @(negedge clk); #1; t++; end
        checks++;
        if (awready !== 1'b1) begin errors++; $display("FAIL aw_handshake: awready=%b required 1", awready); end
        @(posedge clk);
        for (int b = 0; b < n; b++) begin
            @(negedge clk);
            awvalid = 0; wdata = wd[b]; wstrb = ws[b]; wlast = (b == wlast_at); wvalid = 1; #1;
            t = 0;
            while (!wready && t < 50) begin @(negedge clk); #1; t++; end
            checks++;
            if (wready !== 1'b1) begin errors++; $display("FAIL w_handshake beat %0d: wready=%b required 1", b, wready); end
            @(posedge clk);
            ea = beat_addr(a, len, burst, b);
            if (resp_of(ea, len, burst) == OKAY)
                for (int k = 0; k < 4; k++) if (ws[b][k]) model[idx_of(ea)][8*k +: 8] = wd[b][8*k +: 8];
        end
        @(negedge clk);
        wvalid = 0; wlast = 0; bready = 1; #1;
        t = 0;
        while (!bvalid && t < 50) begin @(negedge clk); #1; t++; end
        checks++;
        if (bvalid !== 1'b1) begin errors++; $display("FAIL b_handshake: bvalid=%b required 1", bvalid); end
        resp = bresp; idv = bid;
        @(posedge clk);
        @(negedge clk);
        bready = 0;
    endtask

    // mode 0: rready always high, 1: toggles 1,0,1,0..., 2: random
    task automatic do_read(input logic [3:0] id, input logic [31:0] a, input int len, input logic [1:0] burst, input int mode);
        int t, i, g;
        logic rr, tog;
        logic [31:0] ea, ed;
        logic [1:0] er;
        @(negedge clk);
        arid = id; araddr = a; arlen = 8'(len); arburst = burst; arvalid = 1; #1;
        t = 0;
        while (!arready && t < 50) begin @(negedge clk); #1; t++; end
        checks++;
        if (arready !== 1'b1) begin errors++; $display("FAIL ar_handshake: arready=%b required 1", arready); end
        @(posedge clk);
        @(negedge clk);
        arvalid = 0;
        i = 0; g = 0; tog = 1;
        while (i <= len && g < 2000) begin
            rr = mode == 0 ? 1'b1 : mode == 1 ? tog : 1'($urandom_range(0, 1));
            tog = !tog;
            rready = rr; #1;
            ea = beat_addr(a, len, burst, i);
            er = resp_of(ea, len, burst);
            ed = er == OKAY ? model[idx_of(ea)] : 32'h0;
            checks++;
            if ({rvalid, arready, rid, rresp, rlast, rdata} !== {1'b1, 1'b0, id, er, (i == len), ed}) begin
                errors++;
                $display("FAIL read_beat %0d @%h: got v=%b ar=%b id=%h resp=%h last=%b data=%h, required v=1 ar=0 id=%h resp=%h last=%b data=%h",
                         i, ea, rvalid, arready, rid, rresp, rlast, rdata, id, er, (i == len), ed);
            end
            @(posedge clk);
            @(negedge clk);
            if (rr) i++;
            g++;
        end
        rready = 0; #1;
        checks++;
        if ({rvalid, arready} !== 2'b01) begin
            errors++; $display("FAIL read_end: rvalid=%b arready=%b required 0 1", rvalid, arready);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        arvalid = 1; awvalid = 1; wvalid = 1; #1;
        checks++;
        if ({awready, arready, wready, bvalid, bid, bresp, rvalid, rid, rdata, rresp, rlast} !== 50'h0) begin
            errors++; $display("FAIL reset_outputs: aw=%b ar=%b w=%b b=%b r=%b rdata=%h required all 0",
                               awready, arready, wready, bvalid, rvalid, rdata);
        end
        arvalid = 0; awvalid = 0; wvalid = 0;
        @(negedge clk);
        rst = 0; #1;
        checks++;
        if ({arready, awready, wready} !== 3'b110) begin
            errors++; $display("FAIL idle_ready: arready=%b awready=%b wready=%b required 1 1 0", arready, awready, wready);
        end
        wvalid = 1; #1;
        checks++;
        if (wready !== 1'b0) begin errors++; $display("FAIL idle_wready: wready=%b required 0", wready); end
        @(negedge clk);
        wvalid = 0;
    endtask

    task automatic test_single_write();
        logic [1:0] r; logic [3:0] id;
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        do_write(4'h5, 32'h10, 0, INCR, 0, r, id);
        checks++;
        if ({r, id} !== {OKAY, 4'h5}) begin errors++; $display("FAIL single_write_b: bresp=%h bid=%h required 0 5", r, id); end
        do_read(4'h3, 32'h10, 0, INCR, 0);
    endtask

    task automatic test_strobes();
        logic [1:0] r; logic [3:0] id;
        wd[0] = 32'h11223344; ws[0] = 4'hF;
        do_write(4'h1, 32'h20, 0, INCR, 0, r, id);
        wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
        do_write(4'h2, 32'h20, 0, INCR, 0, r, id);
        checks++;
        if (r !== OKAY) begin errors++; $display("FAIL strobe_b: bresp=%h required 0", r); end
        do_read(4'h2, 32'h20, 0, INCR, 0);
    endtask

    task automatic test_incr_read();
        logic [1:0] r; logic [3:0] id;
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(4'h7, 32'h40, 3, INCR, 3, r, id);
        checks++;
        if ({r, id} !== {OKAY, 4'h7}) begin errors++; $display("FAIL incr_write_b: bresp=%h bid=%h required 0 7", r, id); end
        do_read(4'h9, 32'h40, 3, INCR, 1);
    endtask

    task automatic test_wrap();
        logic [1:0] r; logic [3:0] id;
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(4'h4, 32'h30, 3, INCR, 3, r, id);
        do_read(4'hA, 32'h38, 3, WRAP, 2);
        do_read(4'hB, 32'h38, 2, WRAP, 0);
        do_read(4'hC, 32'h30, 1, RSVD, 0);
        for (int i = 0; i < 3; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(4'hD, 32'h30, 2, WRAP, 2, r, id);
        checks++;
        if ({r, id} !== {SLVERR, 4'hD}) begin errors++; $display("FAIL wrap_len2_b: bresp=%h bid=%h required 2 d", r, id); end
        do_read(4'hE, 32'h30, 3, INCR, 0);
    endtask

    task automatic test_range();
        logic [1:0] r; logic [3:0] id;
        wd[0] = $urandom; ws[0] = 4'hF;
        do_write(4'h1, BASE, 0, INCR, 0, r, id);
        wd[0] = ~wd[0];
        do_write(4'h2, BASE + 32'(4 * DEPTH), 0, INCR, 0, r, id);
        checks++;
        if (r !== DECERR) begin errors++; $display("FAIL range_write_b: bresp=%h required 3", r); end
        do_read(4'h2, BASE, 0, INCR, 0);
        wd[0] = $urandom;
        do_write(4'h3, BASE + 32'(4 * DEPTH - 4), 0, INCR, 0, r, id);
        do_read(4'h3, BASE + 32'(4 * DEPTH - 4), 1, INCR, 0);
        for (int i = 0; i < 2; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(4'h6, BASE + 32'(4 * DEPTH - 4), 1, INCR, 1, r, id);
        checks++;
        if (r !== DECERR) begin errors++; $display("FAIL range_burst_b: bresp=%h required 3", r); end
        do_read(4'h6, BASE + 32'(4 * DEPTH - 4), 0, INCR, 0);
    endtask

    task automatic test_wlast_mismatch();
        logic [1:0] r; logic [3:0] id;
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(4'h1, 32'h200, 3, INCR, 3, r, id);
        for (int i = 0; i < 4; i++) wd[i] = $urandom;
        do_write(4'h8, 32'h200, 3, INCR, 1, r, id);
        checks++;
        if ({r, id} !== {SLVERR, 4'h8}) begin errors++; $display("FAIL wlast_early_b: bresp=%h bid=%h required 2 8", r, id); end
        do_read(4'h8, 32'h200, 3, INCR, 0);
        for (int i = 0; i < 2; i++) wd[i] = $urandom;
        do_write(4'h9, 32'h210, 1, INCR, 255, r, id);
        checks++;
        if (r !== SLVERR) begin errors++; $display("FAIL wlast_missing_b: bresp=%h required 2", r); end
        do_read(4'h9, 32'h210, 1, INCR, 0);
    endtask

    task automatic test_priority();
        logic [1:0] r; logic [3:0] id;
        logic [31:0] v;
        wd[0] = $urandom; ws[0] = 4'hF;
        do_write(4'h0, 32'h80, 0, INCR, 0, r, id);
        @(negedge clk);
        arid = 4'h1; araddr = 32'h80; arlen = 0; arburst = INCR; arvalid = 1;
        awid = 4'h6; awaddr = 32'h84; awlen = 0; awburst = INCR; awvalid = 1; #1;
        checks++;
        if ({arready, awready} !== 2'b10) begin errors++; $display("FAIL prio_ready: arready=%b awready=%b required 1 0", arready, awready); end
        @(posedge clk);
        @(negedge clk);
        arvalid = 0; rready = 1; #1;
        checks++;
        if ({rvalid, rlast, rdata, awready} !== {1'b1, 1'b1, model[idx_of(32'h80)], 1'b0}) begin
            errors++; $display("FAIL prio_read: rvalid=%b rlast=%b rdata=%h awready=%b required 1 1 %h 0",
                               rvalid, rlast, rdata, awready, model[idx_of(32'h80)]);
        end
        @(posedge clk);
        @(negedge clk);
        rready = 0; #1;
        checks++;
        if ({rvalid, awready} !== 2'b01) begin errors++; $display("FAIL prio_aw_after: rvalid=%b awready=%b required 0 1", rvalid, awready); end
        @(posedge clk);
        @(negedge clk);
        v = $urandom;
        awvalid = 0; wdata = v; wstrb = 4'hF; wlast = 1; wvalid = 1; #1;
        checks++;
        if (wready !== 1'b1) begin errors++; $display("FAIL prio_wready: wready=%b required 1", wready); end
        @(posedge clk);
        model[idx_of(32'h84)] = v;
        @(negedge clk);
        wvalid = 0; wlast = 0; bready = 1; #1;
        checks++;
        if ({bvalid, bid, bresp} !== {1'b1, 4'h6, OKAY}) begin
            errors++; $display("FAIL prio_b: bvalid=%b bid=%h bresp=%h required 1 6 0", bvalid, bid, bresp);
        end
        @(posedge clk);
        @(negedge clk);
        bready = 0;
        do_read(4'h1, 32'h84, 0, INCR, 0);
    endtask

    task automatic test_reset_mid_read();
        logic [1:0] r; logic [3:0] id;
        for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(4'h2, 32'h100, 7, INCR, 7, r, id);
        @(negedge clk);
        arid = 4'h2; araddr = 32'h100; arlen = 7; arburst = INCR; arvalid = 1; #1;
        @(posedge clk);
        @(negedge clk);
        arvalid = 0; rready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1; #1;
        checks++;
        if (rvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_read_during: rvalid=%b required 0", rvalid); end
        @(posedge clk);
        @(negedge clk);
        rst = 0; #1;
        checks++;
        if ({rvalid, arready} !== 2'b01) begin errors++; $display("FAIL rst_mid_read_after: rvalid=%b arready=%b required 0 1", rvalid, arready); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            checks++;
            if (rvalid !== 1'b0) begin errors++; $display("FAIL rst_mid_read_idle %0d: rvalid=%b required 0", c, rvalid); end
        end
        rready = 0;
        do_read(4'h5, 32'h100, 1, INCR, 0);
    endtask

    task automatic test_random();
        logic [1:0] r, er, burst; logic [3:0] id, gid;
        logic [31:0] a;
        int len, lens[4] = '{0, 1, 3, 7};
        for (int i = 0; i < 256; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(4'h0, 32'h0, 255, INCR, 255, r, id);
        checks++;
        if (r !== OKAY) begin errors++; $display("FAIL prefill_b: bresp=%h required 0", r); end
        for (int n = 0; n < 40; n++) begin
            burst = 2'($urandom_range(0, 2));
            len = lens[$urandom_range(0, 3)];
            a = 32'($urandom_range(0, 200)) * 4;
            id = 4'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i <= len; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
                er = exp_bresp(a, len, burst, len);
                do_write(id, a, len, burst, len, r, gid);
                checks++;
                if ({r, gid} !== {er, id}) begin
                    errors++; $display("FAIL rand_write %0d @%h: bresp=%h bid=%h required %h %h", n, a, r, gid, er, id);
                end
            end else begin
                do_read(id, a, len, burst, 2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_strobes();
        test_incr_read();
        test_wrap();
        test_range();
        test_wlast_mismatch();
        test_priority();
        test_reset_mid_read();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI4 slave wrapping a word-organised on-chip SRAM.
- Acts as the main memory endpoint that the CPU's I/D cache AXI masters read from and write to.
- Implements FIXED/INCR/WRAP bursts and OKAY/SLVERR/DECERR responses using the shared AXI package types.
- Handles one transaction at a time.

Parameters:
- MEM_DEPTH_WORDS, 4096, number of 32-bit words in the SRAM.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.
- AXI_ADDR_WIDTH / AXI_DATA_WIDTH / AXI_ID_WIDTH / AXI_STRB_WIDTH, 32/32/4/4, taken from the shared AXI package.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- awid  in  4  write ID.
- awaddr  in  32  write start byte address.
- awlen  in  8  beats minus 1.
- awburst  in  2  axi_burst_type_t.
- awvalid  in  1  AW valid.
- awready  out  1  AW ready.
- wdata  in  32  write data.
- wstrb  in  4  byte enables.
- wlast  in  1  last write beat.
- wvalid  in  1  W valid.
- wready  out  1  W ready.
- bid  out  4  echoed awid.
- bresp  out  2  axi_resp_t.
- bvalid  out  1  B valid.
- bready  in  1  B ready.
- arid  in  4  read ID.
- araddr  in  32  read start byte address.
- arlen  in  8  beats minus 1.
- arburst  in  2  axi_burst_type_t.
- arvalid  in  1  AR valid.
- arready  out  1  AR ready.
- rid  out  4  echoed arid.
- rdata  out  32  read data.
- rresp  out  2  per-beat axi_resp_t.
- rlast  out  1  last read beat.
- rvalid  out  1  R valid.
- rready  in  1  R ready.

Behaviour:
- Reset: while rst=1, all outputs are 0 and the FSM goes to IDLE. Reset mid-burst aborts silently, with no B/R response. SRAM contents are not reset.
- Size: every beat is 4 bytes; address bits [1:0] are ignored.
- FSM states: IDLE, WDATA, WRESP, RDATA.
- IDLE:
  - arready=1; awready = !arvalid (read has priority when both are valid).
  - AR handshake latches id, addr, len, burst and goes to RDATA.
  - AW handshake latches the same fields, clears the beat counter and the error accumulator, and goes to WDATA.
- Address generation:
  - FIXED: address held for every beat.
  - INCR: address += 4 per beat.
  - WRAP: address += 4 within a (len+1)*4-byte aligned window, wrapping to the window base.
  - WRAP with len not in {1,3,7,15}: every beat gets SLVERR.
  - burst=2'b11 (reserved): every beat gets SLVERR.
- Range check per beat: address outside [BASE_ADDR, BASE_ADDR+4*MEM_DEPTH_WORDS) gives DECERR. Write beats with DECERR or SLVERR do not modify the SRAM; read beats with DECERR or SLVERR return rdata=0.
- WDATA:
  - wready=1.
  - Each W handshake writes the byte lanes enabled by wstrb and increments the beat counter.
  - The burst ends on the beat where wlast=1 or the counter equals len.
  - If wlast and counter==len disagree, the accumulator records SLVERR, and the burst still ends at the first of the two.
  - Next state is WRESP.
- WRESP:
  - bvalid=1, bid=latched id.
  - bresp = worst beat response, ordered DECERR > SLVERR > OKAY.
  - Held until bready, then go to IDLE.
- RDATA:
  - The first rvalid is asserted on the cycle after the AR handshake (1-cycle latency).
  - One beat per cycle when rready stays high.
  - rdata/rresp/rlast/rid are held stable while rvalid=1 and rready=0.
  - rlast=1 on beat len. A handshake on rlast goes to IDLE.
  - The next AR is accepted no earlier than the cycle after the rlast handshake.
- Throughput: no W beats are accepted outside WDATA. awready and arready are 0 in all non-IDLE states.

Test Plan:
- Single write: AW addr 0x10, len 0, INCR; W data 0xDEADBEEF, wstrb 4'b1111, wlast 1 -> bresp OKAY, bid=awid. Then AR addr 0x10 -> rdata 0xDEADBEEF, rlast 1, rresp OKAY.
- Byte strobes: word 0x20 holds 0x11223344; write 0xAABBCCDD with wstrb 4'b0101 -> read returns 0x11BB33DD.
- INCR read: len 3 from 0x40 -> four beats, words 0x40/0x44/0x48/0x4C, rlast only on beat 4. With rready toggled 1,0,1,0 -> data held stable during stalls.
- WRAP read: len 3 from 0x38 -> beat addresses 0x38, 0x3C, 0x30, 0x34. WRAP with len 2 -> all beats SLVERR, rdata 0.
- Range: write at BASE_ADDR+4*MEM_DEPTH_WORDS -> bresp DECERR, memory unchanged. INCR len 1 read starting at the last valid word -> beat 0 OKAY, beat 1 DECERR.
- Corner cases:
  - awvalid and arvalid in the same cycle -> read served first, write accepted after the rlast handshake.
  - wlast=1 on beat 1 of a len-3 burst -> bresp SLVERR, only 2 words written.
  - rst asserted mid-read -> rvalid=0 on the next cycle, no further beats.
